d_mem_bridge: RTL and testbench

- Sits directly downstream of the data-cache controller and bridges it to the 32-bit backing-memory bus.
- Serves 128-bit line refills as four 32-bit read beats.
- Queues write-through stores in a small posted write buffer.
- Drains all queued writes before any refill, so a refill never returns stale data.

---
 rtl/d_mem_bridge.sv | 199 +++++++++++++++++++
 tb/tb_d_mem_bridge.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/d_mem_bridge.sv
// d_mem_bridge: data-cache refill / posted write-through bridge to a 32-bit memory bus.
// Define D_MEM_WBUF_COALESCE_EN to merge same-address stores into the newest queued entry.
module d_mem_bridge #(
    parameter int WBUF_DEPTH  = 4,
    parameter int LINE_ADDR_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   r_req_i,
    input  logic [LINE_ADDR_W-1:0] line_addr_i,
    output logic                   mem_comp_o,
    output logic [127:0]           line_data_o,
    input  logic                   w_req_i,
    input  logic [LINE_ADDR_W-1:0] w_addr_i,
    input  logic [1:0]             w_offset_i,
    input  logic [31:0]            w_data_i,
    output logic                   wbuf_full_o,
    output logic                   wbuf_overflow_o,
    output logic                   bus_req_o,
    output logic                   bus_we_o,
    output logic [LINE_ADDR_W+1:0] bus_addr_o,
    output logic [31:0]            bus_wdata_o,
    input  logic                   bus_gnt_i,
    input  logic                   bus_rvalid_i,
    input  logic [31:0]            bus_rdata_i
);

    localparam int AW = LINE_ADDR_W + 2;
    localparam int PW = $clog2(WBUF_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        RD_ISSUE,
        RD_WAIT,
        RD_HOLD
    } state_t;

    state_t state, state_n;

    logic [LINE_ADDR_W-1:0] wb_addr [WBUF_DEPTH];
    logic [1:0]             wb_off  [WBUF_DEPTH];
    logic [31:0]            wb_data [WBUF_DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_n;
    logic          full, empty, pop, hit, alloc, drop;
    logic [31:0]   head_wdata;

    logic [LINE_ADDR_W-1:0] line_q, line_n;
    logic [1:0]             beat_q, beat_n;
    logic [31:0]            slot [4];

    logic          req_n, we_n, comp_n;
    logic [AW-1:0] addr_n;
    logic [31:0]   wdata_n;

    assign full  = (count == CW'(WBUF_DEPTH));
    assign empty = (count == '0);
    assign pop   = (state == WR_ISSUE) && bus_req_o && bus_gnt_i;

`ifdef D_MEM_WBUF_COALESCE_EN
    logic [PW-1:0] last_ptr;
    assign last_ptr = wr_ptr - PW'(1);
    // The head being offered on the bus must keep its data, so it is not merged.
    assign hit = !empty
              && (wb_addr[last_ptr] == w_addr_i)
              && (wb_off[last_ptr] == w_offset_i)
              && !((last_ptr == rd_ptr) && (state == WR_ISSUE));
    assign head_wdata = (w_req_i && hit && (last_ptr == rd_ptr))
                      ? w_data_i : wb_data[rd_ptr];
`else
    assign hit        = 1'b0;
    assign head_wdata = wb_data[rd_ptr];
`endif

    assign alloc   = w_req_i && !hit && (!full || pop);
    assign drop    = w_req_i && !hit && full && !pop;
    assign count_n = count + CW'(alloc) - CW'(pop);

    always_ff @(posedge clk) begin
        if (alloc) begin
            wb_addr[wr_ptr] <= w_addr_i;
            wb_off[wr_ptr]  <= w_offset_i;
            wb_data[wr_ptr] <= w_data_i;
        end
`ifdef D_MEM_WBUF_COALESCE_EN
        if (w_req_i && hit)
            wb_data[last_ptr] <= w_data_i;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            wbuf_full_o     <= 1'b0;
            wbuf_overflow_o <= 1'b0;
        end else begin
            if (alloc)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count       <= count_n;
            wbuf_full_o <= (count_n == CW'(WBUF_DEPTH));
            if (drop)
                wbuf_overflow_o <= 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        line_n  = line_q;
        beat_n  = beat_q;
        comp_n  = 1'b0;
        req_n   = 1'b0;
        we_n    = 1'b0;
        addr_n  = '0;
        wdata_n = '0;
        unique case (state)
            IDLE: begin
                if (r_req_i && empty) begin
                    state_n = RD_ISSUE;
                    line_n  = line_addr_i;
                    beat_n  = 2'd0;
                end else if (!empty) begin
                    state_n = WR_ISSUE;
                end
            end
            WR_ISSUE: begin
                if (bus_gnt_i)
                    state_n = IDLE;
            end
            RD_ISSUE: begin
                if (bus_gnt_i)
                    state_n = RD_WAIT;
            end
            RD_WAIT: begin
                if (bus_rvalid_i) begin
                    if (beat_q == 2'd3) begin
                        state_n = RD_HOLD;
                        comp_n  = 1'b1;
                    end else begin
                        state_n = RD_ISSUE;
                        beat_n  = beat_q + 2'd1;
                    end
                end
            end
            RD_HOLD: begin
                if (!r_req_i)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Bus outputs are registered, so they are derived from the next state.
        if (state_n == WR_ISSUE) begin
            req_n   = 1'b1;
            we_n    = 1'b1;
            addr_n  = {wb_addr[rd_ptr], wb_off[rd_ptr]};
            wdata_n = head_wdata;
        end else if (state_n == RD_ISSUE) begin
            req_n  = 1'b1;
            addr_n = {line_n, beat_n};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            line_q      <= '0;
            beat_q      <= '0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            mem_comp_o  <= 1'b0;
            line_data_o <= '0;
            for (int i = 0; i < 4; i++)
                slot[i] <= '0;
        end else begin
            state       <= state_n;
            line_q      <= line_n;
            beat_q      <= beat_n;
            bus_req_o   <= req_n;
            bus_we_o    <= we_n;
            bus_addr_o  <= addr_n;
            bus_wdata_o <= wdata_n;
            mem_comp_o  <= comp_n;
            if ((state == RD_WAIT) && bus_rvalid_i) begin
                slot[beat_q] <= bus_rdata_i;
                if (beat_q == 2'd3)
                    line_data_o <= {bus_rdata_i, slot[2], slot[1], slot[0]};
            end
        end
    end

endmodule

// File: tb/tb_d_mem_bridge.sv
// tb_d_mem_bridge: directed bench for d_mem_bridge with a small bus responder.
// Build with D_MEM_WBUF_COALESCE_EN to exercise store merging.
module tb_d_mem_bridge;

    logic         clk = 1'b0;
    logic         reset;
    logic         r_req_i;
    logic [7:0]   line_addr_i;
    logic         mem_comp_o;
    logic [127:0] line_data_o;
    logic         w_req_i;
    logic [7:0]   w_addr_i;
    logic [1:0]   w_offset_i;
    logic [31:0]  w_data_i;
    logic         wbuf_full_o;
    logic         wbuf_overflow_o;
    logic         bus_req_o;
    logic         bus_we_o;
    logic [9:0]   bus_addr_o;
    logic [31:0]  bus_wdata_o;
    logic         bus_gnt_i;
    logic         bus_rvalid_i;
    logic [31:0]  bus_rdata_i;

    always #5 clk = ~clk;

    d_mem_bridge #(.WBUF_DEPTH(4), .LINE_ADDR_W(8)) dut (
        .clk(clk),
        .reset(reset),
        .r_req_i(r_req_i),
        .line_addr_i(line_addr_i),
        .mem_comp_o(mem_comp_o),
        .line_data_o(line_data_o),
        .w_req_i(w_req_i),
        .w_addr_i(w_addr_i),
        .w_offset_i(w_offset_i),
        .w_data_i(w_data_i),
        .wbuf_full_o(wbuf_full_o),
        .wbuf_overflow_o(wbuf_overflow_o),
        .bus_req_o(bus_req_o),
        .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o),
        .bus_gnt_i(bus_gnt_i),
        .bus_rvalid_i(bus_rvalid_i),
        .bus_rdata_i(bus_rdata_i)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    logic [9:0]  acc_addr [$];
    logic        acc_we   [$];
    logic [31:0] acc_data [$];
    int          comp_cnt = 0;
    int          comp_cyc = 0;
    logic [31:0] rbase = '0;
    int          skip_beat = -1;
    int          inject_req = 0;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        acc_addr.delete();
        acc_we.delete();
        acc_data.delete();
    endtask

    task automatic wait_comp(input int base, input string tag);
        int k = 0;
        while (comp_cnt == base && k < 100) begin
            tick();
            k++;
        end
        check(tag, 128'(comp_cnt - base), 128'(1));
    endtask

    task automatic push(input logic [7:0] a, input logic [1:0] o,
                        input logic [31:0] d);
        w_req_i    = 1'b1;
        w_addr_i   = a;
        w_offset_i = o;
        w_data_i   = d;
        tick();
        w_req_i    = 1'b0;
    endtask

    // Bus responder: logs accepted transfers, returns read data one cycle after grant.
    initial begin : resp
        logic       pend;
        logic       inj;
        logic [1:0] pb;
        int         inj_seen;
        pend = 1'b0;
        inj = 1'b0;
        pb = '0;
        inj_seen = 0;
        bus_rvalid_i = 1'b0;
        bus_rdata_i = '0;
        forever begin
            @(negedge clk);
            if (mem_comp_o) begin
                comp_cnt++;
                comp_cyc = cyc;
            end
            pend = 1'b0;
            inj = (inject_req != inj_seen);
            inj_seen = inject_req;
            if (bus_req_o && bus_gnt_i && !reset) begin
                acc_addr.push_back(bus_addr_o);
                acc_we.push_back(bus_we_o);
                acc_data.push_back(bus_wdata_o);
                if (!bus_we_o && int'(bus_addr_o[1:0]) != skip_beat) begin
                    pend = 1'b1;
                    pb = bus_addr_o[1:0];
                end
            end
            @(posedge clk);
            #1;
            bus_rvalid_i = pend || inj;
            bus_rdata_i = rbase + 32'(pb);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t0;
        int base;
        int k;
        reset = 1'b1;
        r_req_i = 1'b0;
        line_addr_i = '0;
        w_req_i = 1'b0;
        w_addr_i = '0;
        w_offset_i = '0;
        w_data_i = '0;
        bus_gnt_i = 1'b0;
        repeat (3) tick();
        check("rst_req", 128'(bus_req_o), 128'(0));
        check("rst_comp", 128'(mem_comp_o), 128'(0));
        check("rst_line", line_data_o, 128'(0));
        check("rst_full", 128'(wbuf_full_o), 128'(0));
        check("rst_ovf", 128'(wbuf_overflow_o), 128'(0));
        reset = 1'b0;
        tick();

        // Plain refill with immediate grant
        clr();
        rbase = 32'h100;
        bus_gnt_i = 1'b1;
        r_req_i = 1'b1;
        line_addr_i = 8'h2A;
        t0 = cyc;
        base = comp_cnt;
        tick();
        check("rf_req", 128'(bus_req_o), 128'(1));
        check("rf_we", 128'(bus_we_o), 128'(0));
        check("rf_addr0", 128'(bus_addr_o), 128'(10'h0A8));
        wait_comp(base, "rf_comp");
        check("rf_lat", 128'(comp_cyc - t0), 128'(9));
        check("rf_line", line_data_o,
              128'h00000103_00000102_00000101_00000100);
        check("rf_nacc", 128'(acc_addr.size()), 128'(4));
        for (int i = 0; i < 4; i++)
            check($sformatf("rf_ba%0d", i), 128'(acc_addr[i]),
                  128'(10'h0A8 + i));
        repeat (3) tick();
        check("rf_hold_req", 128'(bus_req_o), 128'(0));
        check("rf_hold_once", 128'(comp_cnt - base), 128'(1));
        check("rf_pulse", 128'(mem_comp_o), 128'(0));
        check("rf_line_held", line_data_o,
              128'h00000103_00000102_00000101_00000100);
        r_req_i = 1'b0;
        repeat (2) tick();

        // Stores drain before the refill
        clr();
        rbase = 32'h200;
        bus_gnt_i = 1'b0;
        push(8'h11, 2'd1, 32'hAAAA0001);
        push(8'h12, 2'd0, 32'hBBBB0002);
        push(8'h13, 2'd3, 32'hCCCC0003);
        r_req_i = 1'b1;
        line_addr_i = 8'h05;
        tick();
        bus_gnt_i = 1'b1;
        base = comp_cnt;
        wait_comp(base, "wr_comp");
        check("wr_nacc", 128'(acc_addr.size()), 128'(7));
        check("wr_a0", 128'(acc_addr[0]), 128'(10'h045));
        check("wr_a1", 128'(acc_addr[1]), 128'(10'h048));
        check("wr_a2", 128'(acc_addr[2]), 128'(10'h04F));
        check("wr_d0", 128'(acc_data[0]), 128'(32'hAAAA0001));
        check("wr_d1", 128'(acc_data[1]), 128'(32'hBBBB0002));
        check("wr_d2", 128'(acc_data[2]), 128'(32'hCCCC0003));
        check("wr_we", 128'({acc_we[0], acc_we[1], acc_we[2], acc_we[3]}),
              128'(4'b1110));
        check("wr_rd0", 128'(acc_addr[3]), 128'(10'h014));
        check("wr_line", line_data_o,
              128'h00000203_00000202_00000201_00000200);
        r_req_i = 1'b0;
        repeat (2) tick();

        // Grant stall on a read beat
        clr();
        rbase = 32'h300;
        bus_gnt_i = 1'b0;
        r_req_i = 1'b1;
        line_addr_i = 8'h33;
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("st_req%0d", i), 128'(bus_req_o), 128'(1));
            check($sformatf("st_addr%0d", i), 128'(bus_addr_o),
                  128'(10'h0CC));
            tick();
        end
        bus_gnt_i = 1'b1;
        base = comp_cnt;
        wait_comp(base, "st_comp");
        check("st_nacc", 128'(acc_addr.size()), 128'(4));
        for (int i = 0; i < 4; i++)
            check($sformatf("st_ba%0d", i), 128'(acc_addr[i]),
                  128'(10'h0CC + i));
        check("st_line", line_data_o,
              128'h00000303_00000302_00000301_00000300);
        r_req_i = 1'b0;
        repeat (2) tick();

        // Write buffer overflow
        clr();
        bus_gnt_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(8'h50 + 8'(i), 2'(i), 32'h5000 + 32'(i));
            if (i == 2)
                check("ov_full3", 128'(wbuf_full_o), 128'(0));
            if (i == 3) begin
                check("ov_full4", 128'(wbuf_full_o), 128'(1));
                check("ov_ovf4", 128'(wbuf_overflow_o), 128'(0));
            end
        end
        check("ov_ovf5", 128'(wbuf_overflow_o), 128'(1));
        check("ov_full5", 128'(wbuf_full_o), 128'(1));
        bus_gnt_i = 1'b1;
        repeat (12) tick();
        check("ov_nacc", 128'(acc_addr.size()), 128'(4));
        check("ov_last", 128'(acc_data[3]), 128'(32'h5003));
        check("ov_full_drain", 128'(wbuf_full_o), 128'(0));
        check("ov_sticky", 128'(wbuf_overflow_o), 128'(1));

        // Reset while waiting on beat 2
        clr();
        rbase = 32'h400;
        skip_beat = 2;
        r_req_i = 1'b1;
        line_addr_i = 8'h40;
        k = 0;
        while (acc_addr.size() < 3 && k < 50) begin
            tick();
            k++;
        end
        check("rs_beat2", 128'(acc_addr.size()), 128'(3));
        tick();
        reset = 1'b1;
        r_req_i = 1'b0;
        base = comp_cnt;
        tick();
        check("rs_req", 128'(bus_req_o), 128'(0));
        check("rs_ovf", 128'(wbuf_overflow_o), 128'(0));
        reset = 1'b0;
        skip_beat = -1;
        inject_req++;
        repeat (5) tick();
        check("rs_nocomp", 128'(comp_cnt - base), 128'(0));
        check("rs_line", line_data_o, 128'(0));
        check("rs_idle", 128'(bus_req_o), 128'(0));
        clr();
        r_req_i = 1'b1;
        base = comp_cnt;
        tick();
        check("rs_addr0", 128'(bus_addr_o), 128'(10'h100));
        wait_comp(base, "rs_comp");
        check("rs_nacc", 128'(acc_addr.size()), 128'(4));
        check("rs_relin", line_data_o,
              128'h00000403_00000402_00000401_00000400);
        r_req_i = 1'b0;
        repeat (2) tick();

        // Same-address stores
        clr();
        bus_gnt_i = 1'b0;
        push(8'h20, 2'd2, 32'h1);
        push(8'h20, 2'd2, 32'h2);
        tick();
        bus_gnt_i = 1'b1;
        repeat (8) tick();
`ifdef D_MEM_WBUF_COALESCE_EN
        check("co_nacc", 128'(acc_addr.size()), 128'(1));
        check("co_addr", 128'(acc_addr[0]), 128'(10'h082));
        check("co_data", 128'(acc_data[0]), 128'(32'h2));
`else
        check("co_nacc", 128'(acc_addr.size()), 128'(2));
        check("co_addr", 128'(acc_addr[1]), 128'(10'h082));
        check("co_data0", 128'(acc_data[0]), 128'(32'h1));
        check("co_data1", 128'(acc_data[1]), 128'(32'h2));
`endif
        check("co_ovf", 128'(wbuf_overflow_o), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
